// File: rtl/hex_scan_if.sv
// Bundles the load/value input side and the scanned display outputs of hex_scan_driver.
interface hex_scan_if;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        frame_done;

    modport master (
        output load, value, blank_lz,
        input  digit, an, frame_done
    );

    modport slave (
        input  load, value, blank_lz,
        output digit, an, frame_done
    );
endinterface

// File: rtl/hex_scan_driver.sv
// Time-multiplexes a 16-bit hex value onto one decoder input and a 4-digit
// common-anode display. New values are committed only at a frame boundary.
module hex_scan_driver #(
    parameter int DIVIDER = 50000,
    parameter int CNT_W   = 16
) (
    input  logic      clk,
    input  logic      reset,
    hex_scan_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDER - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [15:0]      disp_reg;
    logic [15:0]      shadow;
    logic             pending;

    logic             tick;
    logic             wrap;
    logic             lz1, lz2, lz3;
    logic             blanked;
    logic [3:0]       digit_next;
    logic [3:0]       an_next;

    // A slot is a leading zero when it and every higher nibble are zero; digit 0 always shows.
    always_comb begin
        tick       = (div_cnt == LAST_CNT);
        wrap       = tick && (idx == 2'd3);
        lz3        = (disp_reg[15:12] == 4'h0);
        lz2        = (disp_reg[15:8]  == 8'h00);
        lz1        = (disp_reg[15:4]  == 12'h000);
        digit_next = disp_reg[{idx, 2'b00} +: 4];
        case (idx)
            2'd1:    blanked = bus.blank_lz && lz1;
            2'd2:    blanked = bus.blank_lz && lz2;
            2'd3:    blanked = bus.blank_lz && lz3;
            default: blanked = 1'b0;
        endcase
        an_next = blanked ? 4'b1111 : ~(4'b0001 << idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt        <= '0;
            idx            <= 2'd0;
            disp_reg       <= 16'h0000;
            shadow         <= 16'h0000;
            pending        <= 1'b0;
            bus.digit      <= 4'h0;
            bus.an         <= 4'b1111;
            bus.frame_done <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
            if (tick) begin
                idx <= idx + 2'd1;
            end

            // The commit uses the pre-edge shadow; a load on the same edge waits for the next wrap.
            if (wrap && pending) begin
                disp_reg <= shadow;
            end
            if (bus.load) begin
                shadow  <= bus.value;
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end

            bus.digit      <= digit_next;
            bus.an         <= an_next;
            bus.frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Drives two hex_scan_driver instances (DIVIDER=4 and DIVIDER=1) with directed and
// random stimulus and compares every cycle against a frame-arithmetic reference model.
module tb_hex_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;

    int checks = 0;
    int passes = 0;

    hex_scan_if bus4 ();
    hex_scan_if bus1 ();

    assign bus4.load     = load;
    assign bus4.value    = value;
    assign bus4.blank_lz = blank_lz;
    assign bus1.load     = load;
    assign bus1.value    = value;
    assign bus1.blank_lz = blank_lz;

    always #5 clk = ~clk;

    hex_scan_driver #(.DIVIDER(4), .CNT_W(3)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    hex_scan_driver #(.DIVIDER(1), .CNT_W(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    // Reference state: edge count since reset locates the scan slot by plain division.
    int          div_of [2] = '{4, 1};
    int unsigned m_n    [2];
    logic [15:0] m_disp [2];
    logic [15:0] m_shadow [2];
    logic        m_pend [2];
    logic [3:0]  e_digit [2];
    logic [3:0]  e_an   [2];
    logic        e_fd   [2];

    function automatic void model_edge(int u);
        int unsigned slot;
        int unsigned frame_len;
        bit          wrap;
        bit          blank;
        if (reset) begin
            m_n[u]      = 0;
            m_disp[u]   = 16'h0000;
            m_shadow[u] = 16'h0000;
            m_pend[u]   = 1'b0;
            e_digit[u]  = 4'h0;
            e_an[u]     = 4'hF;
            e_fd[u]     = 1'b0;
        end else begin
            frame_len  = 4 * div_of[u];
            slot       = (m_n[u] / div_of[u]) % 4;
            wrap       = (m_n[u] % frame_len) == frame_len - 1;
            e_digit[u] = m_disp[u][4*slot +: 4];
            blank      = blank_lz && (slot != 0) && ((m_disp[u] >> (4*slot)) == 16'h0000);
            e_an[u]    = blank ? 4'hF : ~(4'b0001 << slot);
            e_fd[u]    = wrap;
            if (wrap) begin
                if (m_pend[u]) m_disp[u] = m_shadow[u];
                m_pend[u] = 1'b0;
            end
            if (load) begin
                m_shadow[u] = value;
                m_pend[u]   = 1'b1;
            end
            m_n[u]++;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_unit(input int u);
        logic [3:0] d;
        logic [3:0] a;
        logic       f;
        if (u == 0) begin
            d = bus4.digit; a = bus4.an; f = bus4.frame_done;
        end else begin
            d = bus1.digit; a = bus1.an; f = bus1.frame_done;
        end
        checkOutput($sformatf("u%0d digit", u), 16'(d), 16'(e_digit[u]));
        checkOutput($sformatf("u%0d an", u), 16'(a), 16'(e_an[u]));
        checkOutput($sformatf("u%0d frame_done", u), 16'(f), 16'(e_fd[u]));
        checkOutput($sformatf("u%0d single anode", u), 16'($countones(~a) <= 1), 16'd1);
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v);
        reset = r;
        load  = l;
        value = v;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_unit(0);
        check_unit(1);
    endtask

    // Idles until the next edge processes slot s at its first divider count (DIVIDER=4 unit).
    task automatic to_slot(input int s);
        while (!(((m_n[0] / 4) % 4) == s && (m_n[0] % 4) == 0))
            applyStimulus(1'b0, 1'b0, 16'h0000);
    endtask

    logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value    = 16'h0000;
        blank_lz = 1'b0;

        // Reset state and plain scanning of zero
        applyStimulus(1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("reset an", 16'(bus4.an), 16'h000F);
        checkOutput("reset digit", 16'(bus4.digit), 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("first slot an", 16'(bus4.an), 16'h000E);
        repeat (40) applyStimulus(1'b0, 1'b0, 16'h0000);

        // Load mid-frame: committed only after the wrap
        to_slot(1);
        applyStimulus(1'b0, 1'b1, 16'h1A2F);
        for (int k = 0; k < 40 && bus4.frame_done !== 1'b1; k++)
            applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t2 frame_done seen", 16'(bus4.frame_done), 16'h0001);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t2 digit0", 16'(bus4.digit), 16'h000F);
        checkOutput("t2 an0", 16'(bus4.an), 16'h000E);
        repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t2 digit1", 16'(bus4.digit), 16'h0002);
        checkOutput("t2 an1", 16'(bus4.an), 16'h000D);

        // Two loads in one frame, then a load on the wrap edge
        to_slot(0);
        applyStimulus(1'b0, 1'b1, 16'h1234);
        repeat (2) applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'hBEEF);
        while ((m_n[0] % 16) != 15) applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h5555);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t3 last load wins", 16'(bus4.digit), 16'h000F);
        checkOutput("t3 an", 16'(bus4.an), 16'h000E);
        repeat (15) applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t3 wrap-edge load", 16'(bus4.digit), 16'h0005);

        // Leading-zero blanking
        blank_lz = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h0042);
        repeat (20) applyStimulus(1'b0, 1'b0, 16'h0000);
        to_slot(2);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t4 0042 slot2 blank", 16'(bus4.an), 16'h000F);
        to_slot(1);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t4 0042 slot1 an", 16'(bus4.an), 16'h000D);
        checkOutput("t4 0042 slot1 digit", 16'(bus4.digit), 16'h0004);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        repeat (20) applyStimulus(1'b0, 1'b0, 16'h0000);
        to_slot(0);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t4 zero slot0 an", 16'(bus4.an), 16'h000E);
        checkOutput("t4 zero slot0 digit", 16'(bus4.digit), 16'h0000);
        to_slot(1);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t4 zero slot1 blank", 16'(bus4.an), 16'h000F);
        applyStimulus(1'b0, 1'b1, 16'h0102);
        repeat (20) applyStimulus(1'b0, 1'b0, 16'h0000);
        to_slot(1);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t4 0102 inner zero lit", 16'(bus4.an), 16'h000D);
        blank_lz = 1'b0;

        // Reset mid-frame with a pending value
        to_slot(0);
        applyStimulus(1'b0, 1'b1, 16'hABCD);
        to_slot(2);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("t5 reset an", 16'(bus4.an), 16'h000F);
        repeat (40) applyStimulus(1'b0, 1'b0, 16'h0000);
        to_slot(3);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t5 pending dropped", 16'(bus4.digit), 16'h0000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if ($urandom_range(1, 0) == 1) v = v >> (4 * $urandom_range(3, 0));
            if ($urandom_range(3, 0) == 0) blank_lz = ~blank_lz;
            applyStimulus($urandom_range(96, 0) == 0, $urandom_range(5, 0) == 0, v);
        end

        // DIVIDER=1 rotation
        applyStimulus(1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000);
            checkOutput($sformatf("t6 an step%0d", k), 16'(bus1.an), 16'(an_seq[k]));
            checkOutput($sformatf("t6 fd step%0d", k), 16'(bus1.frame_done), 16'(k == 3));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
